// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed 7-segment display block.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD nibble to active-low segment pattern; non-decimal codes show blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 10^n for n in 0..9, used to size the overflow threshold.
  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Latency: BIN_WIDTH cycles after start; done is high during the last shift cycle.
// Backpressure: start is ignored while a conversion is running.
// Ports: clk/rst, start + bin_in (request), done (final shift this cycle),
//        bcd (NUM_DIGITS nibbles, digit 0 in bits [3:0]), overflow (value > 10^NUM_DIGITS-1).
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int BIN_WIDTH  = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    overflow
);

  localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_VAL = pow10(NUM_DIGITS) - 32'd1;

  logic [BIN_WIDTH-1:0]    bin_sh;
  logic [CNT_W-1:0]        cnt;
  logic                    active;
  logic [4*NUM_DIGITS-1:0] bcd_adj;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign done = active && (cnt == CNT_W'(BIN_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      cnt      <= '0;
      bin_sh   <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (start && !active) begin
      active   <= 1'b1;
      cnt      <= '0;
      bin_sh   <= bin_in;
      bcd      <= '0;
      // Digits that fall off the top nibble are irrelevant once this is set.
      overflow <= (32'(bin_in) > MAX_VAL);
    end else if (active) begin
      {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
      cnt           <= cnt + CNT_W'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_display_mux.sv
// Converts a binary value to decimal and time-multiplexes it onto a 7-segment display.
// Latency: load to new digits committed = BIN_WIDTH+1 cycles; outputs lag the scan index by 1 cycle.
// Backpressure: busy high during conversion; load while busy is dropped (no queuing).
// Ports: clk/rst, bin_in + load (request), busy, seg_cathode {g..a}, seg_anode_o (bit 0 = rightmost).
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            seg_cathode,
  output logic [NUM_DIGITS-1:0] seg_anode_o
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                  state, state_nxt;
  logic                    start;
  logic                    cvt_done;
  logic                    cvt_ovf;
  logic [4*NUM_DIGITS-1:0] cvt_bcd;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    disp_ovf;
  logic [PRE_W-1:0]        pre;
  logic [IDX_W-1:0]        idx;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  bin2bcd_seq #(
    .BIN_WIDTH  (BIN_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .done     (cvt_done),
    .bcd      (cvt_bcd),
    .overflow (cvt_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          start     = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT:  if (cvt_done) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Displayed value only changes here, so a reset mid-conversion leaves nothing half-written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
    end else if (state == ST_COMMIT) begin
      disp_bcd <= cvt_bcd;
      disp_ovf <= cvt_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_W'(REFRESH_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Walk from the most significant digit down so zero_above tells whether
  // this digit and everything left of it is zero (leading-zero blanking).
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    seg_nxt    = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_bcd[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == idx) begin
        if (disp_ovf)                 seg_nxt = SEG_DASH;
        else if (zero_above && i > 0) seg_nxt = SEG_BLANK;
        else                          seg_nxt = digit_to_seg(disp_bcd[4*i +: 4]);
      end
    end
    an_nxt = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_cathode <= (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
      seg_anode_o <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      seg_cathode <= (ACTIVE_LOW != 0) ? seg_nxt : ~seg_nxt;
      seg_anode_o <= (ACTIVE_LOW != 0) ? an_nxt  : ~an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: three instances (4-digit active-low, 2-digit active-low,
// 4-digit active-high) driven by shared load/bin_in and checked against a decimal model.
// Ports: all DUT ports connected; clock generated locally.
module tb_seg_display_mux;

  localparam int ND  = 4;
  localparam int BW  = 8;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] bin_in = '0;

  logic       busy, busy2, busy_ah;
  logic [6:0] cath, cath2, cath_ah;
  logic [3:0] an, an_ah;
  logic [1:0] an2;

  int checks = 0;
  int failures = 0;
  int model_val = 0;

  always #5 clk = ~clk;

  seg_display_mux #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .busy(busy),
    .seg_cathode(cath), .seg_anode_o(an));

  seg_display_mux #(.NUM_DIGITS(2), .BIN_WIDTH(BW), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut2 (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .busy(busy2),
    .seg_cathode(cath2), .seg_anode_o(an2));

  seg_display_mux #(.NUM_DIGITS(ND), .BIN_WIDTH(BW), .REFRESH_DIV(DIV), .ACTIVE_LOW(0)) dut_ah (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .busy(busy_ah),
    .seg_cathode(cath_ah), .seg_anode_o(an_ah));

  // Expected active-low pattern for digit i of value v on an nd-digit display.
  function automatic logic [6:0] exp_seg(int v, int i, int nd);
    int lim = 1;
    int pw = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    for (int k = 0; k < i; k++) pw = pw * 10;
    if (v >= lim) return 7'b0111111;
    if (i > 0 && v < pw) return 7'b1111111;
    case ((v / pw) % 10)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Index of the single active anode, or -1 if not exactly one is active.
  function automatic int act_idx(logic [7:0] a, int nd, bit low);
    int n = 0;
    int r = -1;
    for (int k = 0; k < nd; k++) begin
      if (low ? !a[k] : a[k]) begin
        n++;
        r = k;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  // Watch two full scan rounds and compare every visible digit with the model.
  task automatic check_display(string name);
    logic [3:0] seen, seen_ah;
    logic [1:0] seen2;
    int i;
    seen = '0; seen_ah = '0; seen2 = '0;
    @(posedge clk);
    repeat (2 * ND * DIV) begin
      @(negedge clk);
      i = act_idx({4'hf, an}, ND, 1'b1);
      checks++;
      if (i < 0) begin
        failures++;
        $display("FAIL %s anode_onehot: got %b expected one low bit", name, an);
      end else begin
        seen[i] = 1'b1;
        checks++;
        if (cath !== exp_seg(model_val, i, ND)) begin
          failures++;
          $display("FAIL %s digit%0d value=%0d: got %b expected %b", name, i, model_val, cath, exp_seg(model_val, i, ND));
        end
      end
      i = act_idx({4'h0, an_ah}, ND, 1'b0);
      checks++;
      if (i < 0) begin
        failures++;
        $display("FAIL %s ah_anode_onehot: got %b expected one high bit", name, an_ah);
      end else begin
        seen_ah[i] = 1'b1;
        checks++;
        if (cath_ah !== ~exp_seg(model_val, i, ND)) begin
          failures++;
          $display("FAIL %s ah_digit%0d: got %b expected %b", name, i, cath_ah, ~exp_seg(model_val, i, ND));
        end
      end
      i = act_idx({6'h3f, an2}, 2, 1'b1);
      checks++;
      if (i < 0) begin
        failures++;
        $display("FAIL %s nd2_anode_onehot: got %b expected one low bit", name, an2);
      end else begin
        seen2[i] = 1'b1;
        checks++;
        if (cath2 !== exp_seg(model_val, i, 2)) begin
          failures++;
          $display("FAIL %s nd2_digit%0d value=%0d: got %b expected %b", name, i, model_val, cath2, exp_seg(model_val, i, 2));
        end
      end
    end
    checks++;
    if (seen !== 4'hf || seen_ah !== 4'hf || seen2 !== 2'b11) begin
      failures++;
      $display("FAIL %s scan_coverage: got %b/%b/%b expected 1111/1111/11", name, seen, seen_ah, seen2);
    end
  endtask

  task automatic pulse_load(int v);
    @(negedge clk);
    bin_in = BW'(v);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Count busy cycles while confirming the previous value stays on display.
  task automatic count_busy(int old, inout int n);
    int i;
    while (busy === 1'b1 && n < 100) begin
      n++;
      i = act_idx({4'hf, an}, ND, 1'b1);
      if (i >= 0) begin
        checks++;
        if (cath !== exp_seg(old, i, ND)) begin
          failures++;
          $display("FAIL hold_during_shift digit%0d: got %b expected %b", i, cath, exp_seg(old, i, ND));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_load(int v);
    int n = 0;
    int old = model_val;
    pulse_load(v);
    count_busy(old, n);
    checks++;
    if (n != BW + 1) begin
      failures++;
      $display("FAIL busy_len value=%0d: got %0d expected %0d", v, n, BW + 1);
    end
    model_val = v;
    check_display($sformatf("load_%0d", v));
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    logic [1:0] exp_an2;
    int e, e2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 4'b1111 || cath !== 7'b1111111 || busy !== 1'b0 || an2 !== 2'b11) begin
      failures++;
      $display("FAIL reset_outputs: got an=%b cath=%b busy=%b an2=%b expected 1111 1111111 0 11", an, cath, busy, an2);
    end
    checks++;
    if (an_ah !== 4'b0000 || cath_ah !== 7'b0000000 || busy_ah !== 1'b0) begin
      failures++;
      $display("FAIL reset_active_high: got an=%b cath=%b busy=%b expected 0000 0000000 0", an_ah, cath_ah, busy_ah);
    end
    rst = 1'b0;
    model_val = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = ((k - 1) / DIV) % ND;
      e2 = ((k - 1) / DIV) % 2;
      exp_an = 4'b1111;
      exp_an[e] = 1'b0;
      exp_an2 = 2'b11;
      exp_an2[e2] = 1'b0;
      checks++;
      if (an !== exp_an || an2 !== exp_an2) begin
        failures++;
        $display("FAIL scan_order k=%0d: got %b/%b expected %b/%b", k, an, an2, exp_an, exp_an2);
      end
      checks++;
      if (cath !== ((e == 0) ? 7'b1000000 : 7'b1111111)) begin
        failures++;
        $display("FAIL post_reset_digit%0d: got %b expected %b", e, cath, (e == 0) ? 7'b1000000 : 7'b1111111);
      end
    end
  endtask

  task automatic test_directed();
    do_load(4);
    do_load(255);
    do_load(0);
    do_load(100);
    do_load(99);
    do_load(10);
  endtask

  task automatic test_ignore_load();
    int n = 0;
    int old = model_val;
    int late = 0;
    pulse_load(12);
    if (busy === 1'b1) n++;
    @(negedge clk);
    bin_in = BW'(99);
    load = 1'b1;
    if (busy === 1'b1) n++;
    @(negedge clk);
    load = 1'b0;
    count_busy(old, n);
    checks++;
    if (n != BW + 1) begin
      failures++;
      $display("FAIL ignore_busy_len: got %0d expected %0d", n, BW + 1);
    end
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      failures++;
      $display("FAIL ignore_no_queue: got %0d busy cycles expected 0", late);
    end
    model_val = 12;
    check_display("ignore_load");
  endtask

  task automatic test_random();
    repeat (12) do_load(int'($urandom_range(0, 255)));
  endtask

  task automatic test_reset_abort();
    pulse_load(255);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || an !== 4'b1111 || cath !== 7'b1111111) begin
      failures++;
      $display("FAIL abort_reset: got busy=%b an=%b cath=%b expected 0 1111 1111111", busy, an, cath);
    end
    @(negedge clk);
    rst = 1'b0;
    model_val = 0;
    check_display("after_abort");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_load();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter BIN_WIDTH, default 8, width of the unsigned binary input (1..20).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit dwell (>=2).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = cathodes and anodes active-low, 0 = active-high.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port bin_in  input  BIN_WIDTH  unsigned value to display.
REQ-008 SHALL have port load  input  1  single-cycle request to convert and display bin_in.
REQ-009 SHALL have port busy  output  1  conversion in progress.
REQ-010 SHALL have port seg_cathode  output  7  segments {g,f,e,d,c,b,a}.
REQ-011 SHALL have port seg_anode_o  output  NUM_DIGITS  digit enables; bit 0 = rightmost (least significant) digit.

Function
REQ-012 SHALL implement FSM IDLE -> SHIFT -> COMMIT -> IDLE.
REQ-013 IDLE: load=1 SHALL capture bin_in, clear BCD scratch, and enter SHIFT next cycle.
REQ-014 SHIFT SHALL run exactly BIN_WIDTH cycles of sequential double-dabble (add 3 to any nibble >=5, then shift left one bit).
REQ-015 COMMIT SHALL last one cycle and update all displayed digit registers and the overflow flag atomically.
REQ-016 busy SHALL be 1 in SHIFT and COMMIT and 0 in IDLE; load-to-busy-fall latency = BIN_WIDTH+1 cycles.
REQ-017 load while busy=1 SHALL be ignored; no queuing.
REQ-018 If the captured value > 10^NUM_DIGITS-1, the display SHALL show a dash (segment g only) on every digit.
REQ-019 Leading-zero blanking: digit i>0 SHALL be blank when it and all higher digits are 0; digit 0 is never blanked, so value 0 shows a single "0".
REQ-020 Prescaler SHALL count 0..REFRESH_DIV-1; at terminal count the digit index SHALL advance, wrapping NUM_DIGITS-1 -> 0.
REQ-021 Exactly one anode SHALL be active at any time outside reset.
REQ-022 seg_cathode and seg_anode_o SHALL be registered and SHALL reflect the digit index one cycle after it changes.
REQ-023 Decimal digits 0-9 SHALL use standard patterns; active-low examples: 0=1000000, 2=0100100, 4=0011001, 5=0010010, dash=0111111, blank=1111111.
REQ-024 With ACTIVE_LOW=0, both outputs SHALL be the bitwise inverse of the active-low encoding.
REQ-025 The display SHALL keep the last committed value during SHIFT; a new value SHALL take effect only at COMMIT.

Reset
REQ-026 While rst=1: FSM=IDLE, busy=0, prescaler=0, index=0, digit registers=0, overflow=0, all anodes inactive, all cathodes off.
REQ-027 The first rising clk edge after rst falls SHALL drive digit 0 showing "0".
REQ-028 rst during SHIFT or COMMIT SHALL abort the conversion with no partial commit.

Structure
REQ-029 Package seg_display_pkg SHALL hold the segment-pattern constants (0-9, dash, blank) and the FSM state encoding.
REQ-030 Double-dabble datapath SHALL be sub-module bin2bcd_seq (start/done handshake, NUM_DIGITS BCD nibbles plus overflow out); scan and encoding stay in seg_display_mux.

Verification (NUM_DIGITS=4, BIN_WIDTH=8, REFRESH_DIV=4, ACTIVE_LOW=1 unless stated)
REQ-031 Reset then release -> anodes 1111 and cathodes 1111111 during reset; afterwards anodes cycle 1110,1101,1011,0111,1110 every 4 cycles; digit 0 shows 1000000, others blank.
REQ-032 load bin_in=4 -> busy high exactly 9 cycles; digit 0 shows 0011001; digits 1-3 show 1111111.
REQ-033 load bin_in=255 -> digits 2/1/0 show 0100100/0010010/0010010; digit 3 blank.
REQ-034 load 12 then load 99 two cycles later -> second load ignored; final display 12.
REQ-035 NUM_DIGITS=2, load bin_in=100 -> both digits show 0111111.
REQ-036 load 255 then rst asserted 3 cycles later -> busy=0 immediately; after release, display shows "0".
